// File: rtl/uart_tx_param_if.sv
// Host-side handshake bundle for uart_tx_param: parallel word plus valid/ready.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Host drives the word and its valid flag and watches ready.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter consumes the word and reports readiness.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity bit, one or two stop bits. All outputs registered;
// the start bit is driven on the same edge that accepts the word.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_param_if.slave   host,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  // Reject illegal configurations while elaborating.
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              end_of_bit;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    if (PARITY == 2) parity_of = ~(^d);
    else             parity_of = ^d;
  endfunction

  assign end_of_bit    = (cnt_q == CNT_LAST);
  assign host.tx_ready = ready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign tx_done       = done_q;

  // Next-state logic; outputs are derived from the next state so they register
  // in step with it (start bit appears on the acceptance edge).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    unique case (state_q)
      S_IDLE: begin
        if (host.tx_valid && ready_q) begin
          state_d = S_START;
          shift_d = host.tx_data;
          par_d   = parity_of(host.tx_data);
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (end_of_bit) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (end_of_bit) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (end_of_bit) begin
          state_d = S_STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (end_of_bit) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    // Pulse on the final clock of the final stop bit.
    done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (bit_d == STOP_LAST);
  end

  // Control and output registers; reset forces the line idle high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Data word and its parity; only meaningful once a word has been accepted.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations, scoreboard of expected frames
// pushed at stimulus time and compared cycle by cycle by a line monitor.
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus, routed to the selected DUT.
  logic [8:0] tb_data  = '0;
  logic       tb_valid = 1'b0;
  int         sel      = 0;

  uart_tx_param_if #(.DATA_W(8)) ifa ();
  uart_tx_param_if #(.DATA_W(8)) ifb ();
  uart_tx_param_if #(.DATA_W(7)) ifc ();

  assign ifa.tx_data  = tb_data[7:0];
  assign ifb.tx_data  = tb_data[7:0];
  assign ifc.tx_data  = tb_data[6:0];
  assign ifa.tx_valid = tb_valid && (sel == 0);
  assign ifb.tx_valid = tb_valid && (sel == 1);
  assign ifc.tx_valid = tb_valid && (sel == 2);

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .host(ifa), .tx(tx_a), .busy(busy_a), .tx_done(done_a));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .host(ifb), .tx(tx_b), .busy(busy_b), .tx_done(done_b));
  uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .host(ifc), .tx(tx_c), .busy(busy_c), .tx_done(done_c));

  logic mon_tx, mon_busy, mon_done, mon_ready;
  always_comb begin
    mon_tx = tx_a; mon_busy = busy_a; mon_done = done_a; mon_ready = ifa.tx_ready;
    case (sel)
      1: begin mon_tx = tx_b; mon_busy = busy_b; mon_done = done_b; mon_ready = ifb.tx_ready; end
      2: begin mon_tx = tx_c; mon_busy = busy_c; mon_done = done_c; mon_ready = ifc.tx_ready; end
      default: ;
    endcase
  end

  // Configuration of the currently selected DUT, used to build expectations.
  int cur_dw = 8, cur_par = 1, cur_stop = 1, cur_n = 4;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          n;
    int          gap;
  } frame_t;

  frame_t exp_q[$];

  // Reference frame: start, data LSB first, optional parity, stop bits.
  function automatic frame_t mk(input logic [8:0] d, input int dw, input int par,
                                input int stop, input int n, input int gap);
    frame_t f;
    logic   p;
    int     k;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    p         = 1'b0;
    for (int i = 0; i < dw; i++) begin
      f.bits[1+i] = d[i];
      p           = p ^ d[i];
    end
    k = 1 + dw;
    if (par != 0) begin
      f.bits[k] = (par == 2) ? ~p : p;
      k++;
    end
    f.len = k + stop;
    f.n   = n;
    f.gap = gap;
    return f;
  endfunction

  // Line monitor: on each start bit pops an expected frame and checks every
  // clock of it, the tx_done pulse position and the return to idle.
  logic mon_en     = 1'b1;
  logic mon_active = 1'b0;
  int   last_start = 0;

  initial begin : monitor
    logic   prev;
    frame_t f;
    int     e0;
    int     tot;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mon_en && !rst && prev && !mon_tx) begin
        mon_active = 1'b1;
        e0 = cyc;
        chk("acc_ready", {31'd0, mon_ready}, 0);
        chk("acc_busy", {31'd0, mon_busy}, 1);
        chk("frame_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          if (f.gap != 0) chk("b2b_gap", e0 - last_start, f.gap);
          last_start = e0;
          tot = f.len * f.n;
          for (int t = 0; t < tot; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            chk($sformatf("bit%0d", t / f.n), {31'd0, mon_tx}, {31'd0, f.bits[t / f.n]});
            chk($sformatf("done_c%0d", t), {31'd0, mon_done}, {31'd0, t == tot - 1});
          end
          @(posedge clk); #1;
          chk("end_ready", {31'd0, mon_ready}, 1);
          chk("end_busy", {31'd0, mon_busy}, 0);
          chk("end_tx", {31'd0, mon_tx}, 1);
          chk("end_done", {31'd0, mon_done}, 0);
        end
        mon_active = 1'b0;
      end
      prev = mon_tx;
    end
  end

  logic done_seen_a = 1'b0;
  always @(posedge clk) if (done_a) done_seen_a <= 1'b1;

  task automatic wait_ready();
    int n;
    n = 0;
    while (!mon_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("ready_timeout", {31'd0, mon_ready}, 1);
    @(posedge clk);
  endtask

  task automatic send(input logic [8:0] d, input bit expect_it, input int gap);
    if (expect_it) exp_q.push_back(mk(d, cur_dw, cur_par, cur_stop, cur_n, gap));
    @(negedge clk);
    tb_data  = d;
    tb_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, n < 2000}, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic use_cfg(input int s, input int dw, input int par, input int stop, input int n);
    sel = s; cur_dw = dw; cur_par = par; cur_stop = stop; cur_n = n;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    use_cfg(0, 8, 1, 1, 4);

    // Reset values while rst is held.
    chk("rst_tx", {31'd0, mon_tx}, 1);
    chk("rst_ready", {31'd0, mon_ready}, 0);
    chk("rst_busy", {31'd0, mon_busy}, 0);
    chk("rst_done", {31'd0, mon_done}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, mon_ready}, 1);

    // Even parity, 0xA5.
    send(9'h0A5, 1'b1, 0);
    wait_idle();

    // Back-to-back, data changed mid-frame.
    exp_q.push_back(mk(9'h03C, 8, 1, 1, 4, 0));
    exp_q.push_back(mk(9'h0C3, 8, 1, 1, 4, 11 * 4 + 1));
    @(negedge clk);
    tb_data  = 9'h03C;
    tb_valid = 1'b1;
    wait_ready();
    repeat (10) @(negedge clk);
    tb_data = 9'h0C3;
    wait_ready();
    @(negedge clk);
    tb_valid = 1'b0;
    wait_idle();

    // Valid pulsed while busy is ignored.
    send(9'h05A, 1'b1, 0);
    repeat (8) @(negedge clk);
    tb_data  = 9'h0FF;
    tb_valid = 1'b1;
    repeat (3) @(negedge clk);
    tb_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("quiet_tx", {31'd0, mon_tx}, 1);
    chk("quiet_busy", {31'd0, mon_busy}, 0);

    // Odd parity, 0x00.
    use_cfg(1, 8, 2, 1, 4);
    send(9'h000, 1'b1, 0);
    wait_idle();

    // 7 data bits, no parity, two stop bits.
    use_cfg(2, 7, 0, 2, 3);
    send(9'h07F, 1'b1, 0);
    wait_idle();
    send(9'h052, 1'b1, 0);
    wait_idle();

    // Reset in the middle of the data bits.
    use_cfg(0, 8, 1, 1, 4);
    mon_en = 1'b0;
    done_seen_a = 1'b0;
    send(9'h0A5, 1'b0, 0);
    repeat (9) @(negedge clk);
    chk("pre_rst_tx", {31'd0, mon_tx}, 0);
    chk("pre_rst_busy", {31'd0, mon_busy}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, mon_tx}, 1);
    chk("mid_rst_ready", {31'd0, mon_ready}, 0);
    chk("mid_rst_busy", {31'd0, mon_busy}, 0);
    chk("mid_rst_done", {31'd0, mon_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready_rel", {31'd0, mon_ready}, 1);
    repeat (60) @(negedge clk);
    chk("no_done_after_rst", {31'd0, done_seen_a}, 0);
    chk("idle_after_rst", {31'd0, mon_tx}, 1);
    mon_en = 1'b1;

    // Normal frame after the aborted one.
    send(9'h081, 1'b1, 0);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter combining the bit-sequencing FSM, baud-rate counter, bit counter, shift register and parity generator in one block. It accepts a parallel word over a valid/ready handshake and serialises it as start bit, DATA_W data bits LSB first, an optional parity bit, and one or two stop bits. Data width, parity mode, stop-bit count and baud divisor are all set by parameters. It sits between the host-side register/bus logic and the TX pad of the UART_Tx_Rx design.

## Interface
- DATA_W, 8: data bits per frame, legal 5..9.
- CLKS_PER_BIT, 5208: clock cycles per serial bit (N), legal >= 2 (5208 = 50 MHz / 9600 baud).
- PARITY, 1: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: stop bits per frame, legal 1..2.
- Illegal parameter values must fail at elaboration.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_W  word to send, sampled only on the acceptance edge.
- tx_valid  in  1  host has a word.
- tx_ready  out  1  block can accept a word. Registered.
- tx  out  1  serial line, idle high. Registered.
- busy  out  1  frame in progress. Registered.
- tx_done  out  1  one-cycle pulse on the last clock of the last stop bit. Registered.

## Operation
- Reset values: tx=1, tx_ready=0, busy=0, tx_done=0, state IDLE, counters 0. tx_ready rises on the first clock edge after rst falls.
- Acceptance edge: a rising edge where tx_valid=1 and tx_ready=1. tx_data is captured into the shift register and parity is computed from the captured word.
- Parity bit: even = XOR of the data bits, odd = its inverse.
- tx_valid while tx_ready=0 is ignored. There is no queueing, and tx_data changes during a frame have no effect.
- Frame length: F = 1 + DATA_W + (PARITY!=0) + STOP_BITS bits.
- FSM states:
  - IDLE: tx=1, tx_ready=1. On acceptance go to START.
  - START: tx=0. After N cycles go to DATA.
  - DATA: tx = shift register LSB. Every N cycles shift right and increment the bit counter. After bit DATA_W-1 completes, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx = parity bit. After N cycles go to STOP.
  - STOP: tx=1 for STOP_BITS×N cycles, then go to IDLE.
- Baud counter: counts 0..N-1 and is cleared on every state entry. End-of-bit is counter==N-1, so every bit is exactly N cycles long.
- Bit counter: clog2(DATA_W) bits wide; used in DATA and for counting stop bits. It must not wrap within a frame.
- Reset mid-frame: immediate return to reset values and the frame is dropped. No tx_done is issued, and tx returns high asynchronously.

## Timing
- E0 is the acceptance edge. At E0: tx=0, tx_ready=0, busy=1.
- Bit k (0 = start) is driven from edge E0+k×N to E0+(k+1)×N.
- tx_done: set at edge E0+F×N−1, cleared at E0+F×N.
- At E0+F×N: state IDLE, tx_ready=1, busy=0, tx stays 1.
- Back-to-back with tx_valid held high: the next acceptance is at E0+F×N+1. Frame period is F×N+1 clocks, including one extra idle-high clock.
- Latency from acceptance to start-bit falling edge: 0 cycles, i.e. on the same edge.

## Test plan
- Reset: assert rst mid-DATA with N=4 -> tx=1, tx_ready=0, busy=0, tx_done=0 immediately. tx_ready=1 one edge after release, and no tx_done pulse occurs.
- DATA_W=8, N=4, PARITY=1, STOP_BITS=1, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 4 clocks (F=11, 44 clocks). tx_done high on clock 43 after E0; tx_ready=1 at E0+44.
- PARITY=2, send 0x00 -> eight 0 data bits, then parity bit 1, then stop 1.
- DATA_W=7, PARITY=0, STOP_BITS=2, N=3, send 0x7F -> start 0, seven 1s, two stop 1s (F=10, 30 clocks). tx_done at E0+29.
- Back-to-back: tx_valid held, first 0x3C, then tx_data changed to 0xC3 mid-frame -> frame 1 carries 0x3C unchanged. Second acceptance at E0+F×N+1 carries 0xC3.
- tx_valid pulsed during busy, then deasserted -> no second frame, tx stays high after frame 1.
